rpn_stack: RTL
==============

RPN_STACK -- requirements
Module: rpn_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, two's complement.
REQ-002 SHALL have parameter DEPTH, default 8: maximum number of stack entries, minimum 2.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port op  input  3  operation code: 000 DIGIT, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 NEG.
REQ-008 SHALL have port digit  input  4  digit value for DIGIT.
REQ-009 SHALL have port hex  input  1  entry radix for DIGIT: 1 = 16, 0 = 10.
REQ-010 SHALL have port top  output  WIDTH  entry 0, the top of stack.
REQ-011 SHALL have port next  output  WIDTH  entry 1, or 0 when count < 2.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of live entries.
REQ-013 SHALL have port error_code  output  2  result of the last accepted op: 00 ok, 01 overflow (stack full), 10 underflow, 11 bad operand (digit out of range or divide by zero).

Function
REQ-014 SHALL accept an op on a cycle where op_valid and op_ready are both 1; error_code updates on the following edge.
REQ-015 SHALL update top, next and count one cycle after acceptance for every op except DIV.
REQ-016 DIGIT SHALL set top = top*R + digit, where R = 16 when hex is 1 and 10 otherwise, modulo 2^WIDTH; digit >= R SHALL give code 11 and leave top unchanged.
REQ-017 PUSH SHALL push 0, so top becomes 0, next becomes the old top, and count increments; when count == DEPTH it SHALL give code 01 and leave the stack unchanged.
REQ-018 POP SHALL discard top and decrement count; when count == 1 it SHALL give code 10 and leave the stack unchanged.
REQ-019 ADD, SUB, MUL and DIV SHALL compute next+top, next-top, next*top (low WIDTH bits) and next/top respectively; the result SHALL replace both operands, so count decrements and the entries below shift up.
REQ-020 A binary op with count < 2 SHALL give code 10 and leave the stack unchanged.
REQ-021 DIV SHALL be signed and truncate toward zero; top == 0 SHALL give code 11 one cycle after acceptance with the stack unchanged; most-negative / -1 SHALL wrap to most-negative.
REQ-022 NEG SHALL set top = -top modulo 2^WIDTH and leave count unchanged.
REQ-023 The FSM SHALL have states IDLE, DIV_RUN and DIV_FIX; op_ready SHALL be 1 only in IDLE.
REQ-024 An accepted DIV with a nonzero divisor SHALL go IDLE -> DIV_RUN, run WIDTH restoring iterations on magnitudes, then go DIV_RUN -> DIV_FIX, apply the sign and commit, then go DIV_FIX -> IDLE; total latency SHALL be WIDTH+2 cycles from acceptance.
REQ-025 op, digit and hex SHALL be ignored while op_ready is 0; op_valid held high SHALL be accepted again on the first IDLE cycle.
REQ-026 Entries at index >= count SHALL read as 0 and be written to 0 whenever they are vacated.

Reset
REQ-027 reset SHALL force: top 0, next 0, count 1, all entries 0, error_code 00, state IDLE, op_ready 1.
REQ-028 reset asserted during DIV_RUN or DIV_FIX SHALL abort the division with no commit and leave the block in the reset state of REQ-027.
REQ-029 reset SHALL take priority over an op accepted on the same edge.

Configuration
REQ-030 With macro RPN_STACK_DIV_EN defined, DIV and the DIV_RUN/DIV_FIX states SHALL be built as specified above.
REQ-031 Without RPN_STACK_DIV_EN, DIV SHALL give code 11 one cycle after acceptance with the stack unchanged, no divider logic SHALL be present, and op_ready SHALL be constantly 1.

Verification
REQ-032 Reset, then DIGIT 1, 2, 3 with hex=0 -> top 123, count 1, error_code 00.
REQ-033 From top 123: PUSH, DIGIT 9, DIGIT 0, DIGIT 0, ADD -> top 1023, next 0, count 1; then PUSH, DIGIT 8, SUB -> top 1015.
REQ-034 From top 7105: PUSH, DIGIT 6, DIV -> op_ready low for exactly WIDTH+2 cycles, then top 1184, count 1; then NEG, PUSH, DIGIT 5, NEG, DIV -> top 236.
REQ-035 Boundary cases, DEPTH=4:
- four PUSHes -> count 4, and the fourth gives error_code 01;
- POP at count 1 -> error_code 10;
- ADD at count 1 -> error_code 10;
- DIGIT with digit=12 and hex=0 -> error_code 11, top unchanged.
REQ-036 DIV with top 0 -> error_code 11, stack unchanged; reset asserted in cycle 3 of a running DIV -> top 0, count 1, op_ready 1 the next cycle.

Source files
------------

// File: rtl/rpn_stack.sv
// rpn_stack: RPN calculator operand stack with digit entry and ALU ops.
// Ports: clock, reset (sync, high); op_valid/op_ready handshake;
//   op[2:0], digit[3:0], hex in; top, next, count, error_code out.
// Define RPN_STACK_DIV_EN to build the multi-cycle signed divider.
module rpn_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [2:0]                 op,
   input  logic [3:0]                 digit,
   input  logic                       hex,
   output logic [WIDTH-1:0]           top,
   output logic [WIDTH-1:0]           next,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [1:0]                 error_code
);

   localparam int CW = $clog2(DEPTH+1);

   localparam logic [2:0] OP_DIGIT = 3'd0;
   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_MUL   = 3'd5;
   localparam logic [2:0] OP_DIV   = 3'd6;
   localparam logic [2:0] OP_NEG   = 3'd7;

   localparam logic [1:0] E_OK  = 2'b00;
   localparam logic [1:0] E_OVF = 2'b01;
   localparam logic [1:0] E_UNF = 2'b10;
   localparam logic [1:0] E_BAD = 2'b11;

   logic [WIDTH-1:0] stk [DEPTH];
   logic [CW-1:0]    cnt;
   logic [1:0]       err;

   logic             accept;
   logic             full;
   logic             single;
   logic             digit_bad;
   logic [WIDTH-1:0] dec_val;
   logic [WIDTH-1:0] dig_val;
   logic [WIDTH-1:0] arith;

   logic             shift_dn;
   logic             shift_up;
   logic             top_we;
   logic [WIDTH-1:0] top_d;
   logic             err_we;
   logic [1:0]       err_d;

   assign accept = op_valid & op_ready;
   assign full   = (cnt == CW'(DEPTH));
   assign single = (cnt < CW'(2));

   // Hex digits always fit 4 bits, so only decimal entry can be out of range.
   assign digit_bad = !hex && (digit > 4'd9);

   // top*10 as top*8 + top*2 keeps the entry path to shifts and one adder.
   assign dec_val = {stk[0][WIDTH-4:0], 3'b000}
                  + {stk[0][WIDTH-2:0], 1'b0};
   assign dig_val = (hex ? {stk[0][WIDTH-5:0], 4'h0} : dec_val)
                  + {{(WIDTH-4){1'b0}}, digit};

   always_comb begin
      arith = stk[1] + stk[0];
      if (op == OP_SUB) arith = stk[1] - stk[0];
      else if (op == OP_MUL) arith = stk[1] * stk[0];
   end

`ifdef RPN_STACK_DIV_EN
   typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;

   localparam int IW = $clog2(WIDTH+1);

   state_t           state;
   state_t           state_d;
   logic             div_go;
   logic             div_commit;
   logic [IW-1:0]    it;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quo_s;

   assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
   assign quo_s = neg_q ? -quo : quo;
`endif

   always_comb begin
      shift_dn = 1'b0;
      shift_up = 1'b0;
      top_we   = 1'b0;
      top_d    = stk[1];
      err_we   = 1'b0;
      err_d    = E_OK;
`ifdef RPN_STACK_DIV_EN
      div_go   = 1'b0;
`endif
      if (accept) begin
         err_we = 1'b1;
         unique case (op)
            OP_DIGIT: begin
               if (digit_bad) err_d = E_BAD;
               else begin
                  top_we = 1'b1;
                  top_d  = dig_val;
               end
            end
            OP_PUSH: begin
               if (full) err_d = E_OVF;
               else shift_dn = 1'b1;
            end
            OP_POP: begin
               if (single) err_d = E_UNF;
               else shift_up = 1'b1;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
               if (single) err_d = E_UNF;
               else begin
                  shift_up = 1'b1;
                  top_d    = arith;
               end
            end
            OP_DIV: begin
`ifdef RPN_STACK_DIV_EN
               if (single) err_d = E_UNF;
               else if (stk[0] == '0) err_d = E_BAD;
               else div_go = 1'b1;
`else
               err_d = E_BAD;
`endif
            end
            OP_NEG: begin
               top_we = 1'b1;
               top_d  = -stk[0];
            end
         endcase
      end
`ifdef RPN_STACK_DIV_EN
      if (div_commit) begin
         shift_up = 1'b1;
         top_d    = quo_s;
      end
`endif
   end

   // Vacated slots are refilled with zero so index >= count always reads 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
         cnt <= CW'(1);
         err <= E_OK;
      end else begin
         if (err_we) err <= err_d;
         if (shift_dn) begin
            stk[0] <= '0;
            for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
            cnt <= cnt + CW'(1);
         end else if (shift_up) begin
            stk[0] <= top_d;
            for (int i = 1; i < DEPTH-1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            cnt <= cnt - CW'(1);
         end else if (top_we) begin
            stk[0] <= top_d;
         end
      end
   end

`ifdef RPN_STACK_DIV_EN
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (div_go) state_d = DIV_RUN;
         DIV_RUN: if (it == IW'(WIDTH)) state_d = DIV_FIX;
         DIV_FIX: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_ready   = (state == IDLE);
      div_commit = (state == DIV_FIX);
   end

   // Raw operands are latched at accept; the first DIV_RUN cycle takes
   // their magnitudes, the next WIDTH cycles are restoring iterations.
   always_ff @(posedge clock) begin
      if (reset) begin
         it    <= '0;
         quo   <= '0;
         dvs   <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
      end else if (div_go) begin
         it    <= '0;
         quo   <= stk[1];
         dvs   <= stk[0];
         neg_q <= stk[1][WIDTH-1] ^ stk[0][WIDTH-1];
      end else if (state == DIV_RUN) begin
         it <= it + IW'(1);
         if (it == '0) begin
            quo <= quo[WIDTH-1] ? -quo : quo;
            dvs <= dvs[WIDTH-1] ? -dvs : dvs;
            rem <= '0;
         end else if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
         end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
         end
      end
   end
`else
   assign op_ready = 1'b1;
`endif

   assign top        = stk[0];
   assign next       = single ? '0 : stk[1];
   assign count      = cnt;
   assign error_code = err;

endmodule
